// File: rtl/bno055_ring_pkg.sv
// Shared types and helpers for the BNO055 sample ring master:
// FSM state encoding, latency counter sizing, byteenable constant.
package bno055_ring_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_RD_WAIT
   } state_t;

   localparam int BE_MAX = 64;
   localparam logic [BE_MAX-1:0] BE_ONES = '1;

   function automatic int lat_cnt_w(input int lat);
      return (lat < 2) ? 1 : $clog2(lat + 1);
   endfunction

endpackage

// File: rtl/bno055_sample_fifo.sv
// Synchronous sample FIFO, {byteenable, data} per entry,
// pointers carry an extra wrap bit to tell full from empty.
module bno055_sample_fifo
#(
   parameter int W     = 36,
   parameter int DEPTH = 8,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wp;
   logic [AW:0]  r_rp;
   logic         w_wr;
   logic         w_rd;

   assign o_empty = (r_wp == r_rp);
   assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                    (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign w_wr    = i_push & ~o_full;
   assign w_rd    = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rp[AW-1:0]];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wp <= '0;
         r_rp <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + (AW+1)'(1);
         if (w_rd) r_rp <= r_rp + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp[AW-1:0]] <= i_data;
   end

endmodule

// File: rtl/bno055_sample_ring_master.sv
// Avalon-MM master: streams BNO055 samples into a RAM ring
// and serves single-word readbacks with fixed read latency.
module bno055_sample_ring_master
   import bno055_ring_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int BASE_WORD  = 0,
   parameter int RING_WORDS = 256,
   parameter int FIFO_DEPTH = 8,
   parameter int RD_LAT     = 1,
   localparam int BE_W      = DATA_W / 8,
   localparam int IDX_W     = $clog2(RING_WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic [BE_W-1:0]   s_be,
   input  logic              rd_req,
   output logic              rd_ready,
   input  logic [IDX_W-1:0]  rd_index,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W-1:0] avm_address,
   output logic [BE_W-1:0]   avm_byteenable,
   output logic              avm_chipselect,
   output logic              avm_write,
   output logic              avm_read,
   output logic [DATA_W-1:0] avm_writedata,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_waitrequest,
   output logic [IDX_W-1:0]  wr_ptr,
   output logic              wrapped
);

   localparam int CNT_W = lat_cnt_w(RD_LAT);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_WORD);

   state_t                 r_state;
   state_t                 w_next;
   logic [IDX_W-1:0]       r_wr_ptr;
   logic [IDX_W-1:0]       r_rd_idx;
   logic                   r_wrapped;
   logic                   r_pend;
   logic                   r_rd_valid;
   logic [DATA_W-1:0]      r_rd_data;
   logic [CNT_W-1:0]       r_cnt;
   logic                   w_push;
   logic                   w_full;
   logic                   w_empty;
   logic [DATA_W+BE_W-1:0] w_head;
   logic                   w_wr_acc;
   logic                   w_rd_acc;
   logic                   w_last;
   logic                   w_rd_take;

   assign s_ready   = ~reset & ~w_full;
   assign rd_ready  = ~reset & ~r_pend & ~r_rd_valid;
   assign w_push    = s_valid & s_ready;
   assign w_rd_take = rd_req & rd_ready;
   assign rd_valid  = r_rd_valid;
   assign rd_data   = r_rd_data;
   assign wr_ptr    = r_wr_ptr;
   assign wrapped   = r_wrapped;

   bno055_sample_fifo #(
      .W     (DATA_W + BE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  ({s_be, s_data}),
      .i_pop   (w_wr_acc),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_comb begin
      w_next         = r_state;
      w_wr_acc       = 1'b0;
      w_rd_acc       = 1'b0;
      w_last         = 1'b0;
      avm_address    = '0;
      avm_byteenable = '0;
      avm_chipselect = 1'b0;
      avm_write      = 1'b0;
      avm_read       = 1'b0;
      avm_writedata  = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (r_pend)        w_next = ST_READ;
            else if (!w_empty) w_next = ST_WRITE;
         end
         ST_WRITE: begin
            avm_chipselect = 1'b1;
            avm_write      = 1'b1;
            avm_address    = BASE_A + ADDR_W'(r_wr_ptr);
            avm_writedata  = w_head[DATA_W-1:0];
            avm_byteenable = w_head[DATA_W +: BE_W];
            if (!avm_waitrequest) begin
               w_wr_acc = 1'b1;
               w_next   = ST_IDLE;
            end
         end
         ST_READ: begin
            avm_chipselect = 1'b1;
            avm_read       = 1'b1;
            avm_address    = BASE_A + ADDR_W'(r_rd_idx);
            avm_byteenable = BE_ONES[BE_W-1:0];
            if (!avm_waitrequest) begin
               w_rd_acc = 1'b1;
               w_next   = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (r_cnt == CNT_W'(1)) begin
               w_last = 1'b1;
               w_next = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_wr_ptr   <= '0;
         r_rd_idx   <= '0;
         r_wrapped  <= 1'b0;
         r_pend     <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_next;
         r_rd_valid <= w_last;
         if (w_rd_take) begin
            r_pend   <= 1'b1;
            r_rd_idx <= rd_index;
         end else if (w_last) begin
            r_pend   <= 1'b0;
         end
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + IDX_W'(1);
            if (&r_wr_ptr) r_wrapped <= 1'b1;
         end
         // counter runs only while waiting on the slave's q
         if (w_rd_acc)
            r_cnt <= CNT_W'(RD_LAT);
         else if (r_state == ST_RD_WAIT)
            r_cnt <= r_cnt - CNT_W'(1);
         if (w_last) r_rd_data <= avm_readdata;
      end
   end

endmodule
